// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   localparam int UART_OVS       = 16;
   localparam int UART_MID       = 7;
   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   // A divisor of zero would never produce a tick, so it behaves like one.
   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Host-side read and error interface of the UART receiver.
interface uart_rx_ctrl_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS
);

   logic [DATA_BITS-1:0] rd_data;
   logic                 rd_valid;
   logic                 rd_ready;
   logic                 framing_err;
   logic                 overrun_err;
   logic                 err_clr;

   modport master (
      output rd_data,
      output rd_valid,
      output framing_err,
      output overrun_err,
      input  rd_ready,
      input  err_clr
   );

   modport slave (
      input  rd_data,
      input  rd_valid,
      input  framing_err,
      input  overrun_err,
      output rd_ready,
      output err_clr
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO buffering received bytes; head entry is always visible.
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // Extra pointer bit tells full from empty when the indices coincide.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: rx synchroniser, oversample tick generator,
// frame sequencing FSM, error flags and the receive FIFO.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int OVS        = UART_OVS,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] baud_div,
   input  logic        rx,
   output logic        dp_sample,
   output logic        busy,
   uart_rx_ctrl_if.master host
);

   localparam int BW = $clog2(DATA_BITS);

   logic                 rx_meta;
   logic                 rx_s;
   logic [15:0]          div_cnt;
   logic [15:0]          div_cur;
   logic                 tick;
   rx_state_t            state;
   logic [3:0]           os_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 os_last;
   logic                 stop_sample;
   logic                 push_req;
   logic                 push;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 framing_set;
   logic                 overrun_set;
   logic                 framing_err;
   logic                 overrun_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // The divisor in use is only reloaded at a wrap so a change never
   // truncates or stretches the tick period already in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         div_cur <= 16'd1;
      end else if (!enable || tick) begin
         div_cnt <= '0;
         div_cur <= eff_div(baud_div);
      end else begin
         div_cnt <= div_cnt + 16'd1;
      end
   end

   assign tick        = enable && (div_cnt == div_cur - 16'd1);
   assign os_last     = (os_cnt == 4'(OVS - 1));
   assign stop_sample = tick && (state == STOP) && os_last;
   assign push_req    = stop_sample && rx_s;
   assign framing_set = stop_sample && !rx_s;
   assign pop         = !fifo_empty && host.rd_ready;
   assign push        = push_req && (!fifo_full || pop);
   assign overrun_set = push_req && fifo_full && !pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         os_cnt    <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         dp_sample <= 1'b0;
      end else begin
         dp_sample <= 1'b0;
         if (!enable) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
         end else if (tick) begin
            case (state)
               IDLE: begin
                  if (!rx_s) begin
                     state  <= START;
                     os_cnt <= '0;
                  end
               end
               START: begin
                  // A start bit that is high again at its mid-point was a glitch.
                  if (os_cnt == 4'(UART_MID)) begin
                     os_cnt  <= '0;
                     bit_cnt <= '0;
                     state   <= rx_s ? IDLE : DATA;
                  end else begin
                     os_cnt <= os_cnt + 4'd1;
                  end
               end
               DATA: begin
                  if (os_last) begin
                     shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                     dp_sample <= 1'b1;
                     bit_cnt   <= bit_cnt + 1'b1;
                     os_cnt    <= '0;
                     if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        state <= STOP;
                     end
                  end else begin
                     os_cnt <= os_cnt + 4'd1;
                  end
               end
               STOP: begin
                  if (os_last) begin
                     os_cnt <= '0;
                     state  <= rx_s ? IDLE : WAIT_HIGH;
                  end else begin
                     os_cnt <= os_cnt + 4'd1;
                  end
               end
               WAIT_HIGH: begin
                  // Hold off until the line returns high so a break is not a new start.
                  if (rx_s) begin
                     state <= IDLE;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         framing_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         if (framing_set) begin
            framing_err <= 1'b1;
         end else if (host.err_clr) begin
            framing_err <= 1'b0;
         end
         if (overrun_set) begin
            overrun_err <= 1'b1;
         end else if (host.err_clr) begin
            overrun_err <= 1'b0;
         end
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (shift_reg),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (host.rd_data)
   );

   assign host.rd_valid    = !fifo_empty;
   assign host.framing_err = framing_err;
   assign host.overrun_err = overrun_err;
   assign busy             = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: drives serial frames and compares
// against a queue-based model of the receive buffer and error flags.
module tb_uart_rx_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] baud_div;
   logic        rx;
   logic        dp_sample;
   logic        busy;

   uart_rx_ctrl_if #(.DATA_BITS(8)) bus ();

   uart_rx_ctrl #(
      .DATA_BITS  (8),
      .OVS        (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .baud_div  (baud_div),
      .rx        (rx),
      .dp_sample (dp_sample),
      .busy      (busy),
      .host      (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   logic [7:0] exp_q[$];
   logic       exp_ovr;
   logic       exp_fe;

   int         cyc = 0;
   int         dp_total = 0;
   int         dp_last = 0;
   int         dp_gap = 0;
   logic [7:0] dp_bits = 8'h00;

   always @(posedge clk) cyc++;

   // Record the line level the bench is driving at each mid-bit strobe.
   always @(negedge clk) begin
      if (dp_sample === 1'b1) begin
         dp_total++;
         dp_gap  = cyc - dp_last;
         dp_last = cyc;
         dp_bits = {rx, dp_bits[7:1]};
      end
   end

   task automatic send_frame(input logic [7:0] data, input logic stop_val,
                             input int bit_clks, input int stop_clks);
      rx = 1'b0;
      repeat (bit_clks) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         repeat (bit_clks) @(negedge clk);
      end
      rx = stop_val;
      repeat (stop_clks) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic model_push(input logic [7:0] b);
      if (exp_q.size() == 4) exp_ovr = 1'b1;
      else exp_q.push_back(b);
   endtask

   task automatic pop_one();
      @(negedge clk) bus.rd_ready = 1'b1;
      @(negedge clk) bus.rd_ready = 1'b0;
   endtask

   task automatic pulse_err_clr();
      @(negedge clk) bus.err_clr = 1'b1;
      @(negedge clk) bus.err_clr = 1'b0;
      exp_ovr = 1'b0;
      exp_fe  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; baud_div = 16'd1; rx = 1'b1;
      bus.rd_ready = 1'b0; bus.err_clr = 1'b0;
      exp_ovr = 1'b0; exp_fe = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.rd_valid !== 1'b0) $display("[TB] FAIL reset_rd_valid: got %b want 0", bus.rd_valid); else passes++;
      checks++; if (bus.rd_data !== 8'h00) $display("[TB] FAIL reset_rd_data: got %h want 00", bus.rd_data); else passes++;
      checks++; if ({bus.framing_err, bus.overrun_err} !== 2'b00) $display("[TB] FAIL reset_errs: got %b want 00", {bus.framing_err, bus.overrun_err}); else passes++;
      checks++; if ({busy, dp_sample} !== 2'b00) $display("[TB] FAIL reset_busy_dp: got %b want 00", {busy, dp_sample}); else passes++;
      enable = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   // At divisor 1 every clk is a tick, so the stop-bit sample lands a fixed
   // 154 edges after the start edge is driven (2 sync + 8 + 9*16).
   task automatic test_valid_byte(input logic [15:0] div, input logic [7:0] b);
      int eff;
      int dp0;
      eff = (div == 16'd0) ? 1 : int'(div);
      baud_div = div;
      repeat (12) @(negedge clk);
      dp0 = dp_total;
      fork
         send_frame(b, 1'b1, 16 * eff, 16 * eff);
         if (eff == 1 && exp_q.size() == 0) begin
            repeat (154) @(posedge clk);
            @(negedge clk);
            checks++; if (bus.rd_valid !== 1'b0) $display("[TB] FAIL latency_early: rd_valid %b want 0", bus.rd_valid); else passes++;
            @(negedge clk);
            checks++; if (bus.rd_valid !== 1'b1) $display("[TB] FAIL latency_rise: rd_valid %b want 1", bus.rd_valid); else passes++;
         end
      join
      model_push(b);
      repeat (32 * eff) @(negedge clk);
      checks++; if (dp_total - dp0 !== 8) $display("[TB] FAIL dp_count: got %0d want 8", dp_total - dp0); else passes++;
      checks++; if (dp_bits !== b) $display("[TB] FAIL dp_midbit: got %h want %h", dp_bits, b); else passes++;
      checks++; if (dp_gap !== 16 * eff) $display("[TB] FAIL dp_gap: got %0d want %0d", dp_gap, 16 * eff); else passes++;
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_q[0]) $display("[TB] FAIL byte_rx: got v=%b d=%h want v=1 d=%h", bus.rd_valid, bus.rd_data, exp_q[0]); else passes++;
      checks++; if ({bus.framing_err, bus.overrun_err} !== {exp_fe, exp_ovr}) $display("[TB] FAIL byte_errs: got %b want %b", {bus.framing_err, bus.overrun_err}, {exp_fe, exp_ovr}); else passes++;
      pop_one();
      void'(exp_q.pop_front());
      checks++; if (bus.rd_valid !== (exp_q.size() != 0)) $display("[TB] FAIL byte_pop: rd_valid %b want %b", bus.rd_valid, exp_q.size() != 0); else passes++;
   endtask

   task automatic test_glitch();
      int dp0;
      baud_div = 16'd1;
      repeat (10) @(negedge clk);
      dp0 = dp_total;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      checks++; if (busy !== 1'b1) $display("[TB] FAIL glitch_busy_hi: got %b want 1", busy); else passes++;
      repeat (20) @(negedge clk);
      checks++; if (busy !== 1'b0) $display("[TB] FAIL glitch_busy_lo: got %b want 0", busy); else passes++;
      checks++; if ({bus.rd_valid, bus.framing_err, bus.overrun_err} !== 3'b000) $display("[TB] FAIL glitch_side: got %b want 000", {bus.rd_valid, bus.framing_err, bus.overrun_err}); else passes++;
      checks++; if (dp_total !== dp0) $display("[TB] FAIL glitch_dp: got %0d pulses want 0", dp_total - dp0); else passes++;
   endtask

   task automatic test_framing();
      baud_div = 16'd1;
      repeat (10) @(negedge clk);
      fork
         send_frame(8'h3C, 1'b0, 16, 40);
         begin
            repeat (170) @(negedge clk);
            checks++; if (bus.framing_err !== 1'b1) $display("[TB] FAIL framing_set: got %b want 1", bus.framing_err); else passes++;
            checks++; if (busy !== 1'b1) $display("[TB] FAIL framing_wait_high: busy %b want 1", busy); else passes++;
            checks++; if (bus.rd_valid !== 1'b0) $display("[TB] FAIL framing_no_push: rd_valid %b want 0", bus.rd_valid); else passes++;
         end
      join
      exp_fe = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (busy !== 1'b0) $display("[TB] FAIL framing_release: busy %b want 0", busy); else passes++;
      test_valid_byte(16'd1, 8'h11);
      pulse_err_clr();
      checks++; if (bus.framing_err !== 1'b0) $display("[TB] FAIL framing_clr: got %b want 0", bus.framing_err); else passes++;
   endtask

   task automatic test_overrun();
      baud_div = 16'd1;
      bus.rd_ready = 1'b0;
      repeat (10) @(negedge clk);
      for (int k = 1; k <= 5; k++) begin
         send_frame(8'(k), 1'b1, 16, 16);
         model_push(8'(k));
         if (k == 4) begin
            checks++; if (bus.rd_valid !== 1'b1 || bus.overrun_err !== 1'b0) $display("[TB] FAIL overrun_fill: got v=%b ovr=%b want v=1 ovr=0", bus.rd_valid, bus.overrun_err); else passes++;
         end
      end
      repeat (20) @(negedge clk);
      checks++; if (bus.overrun_err !== exp_ovr) $display("[TB] FAIL overrun_set: got %b want %b", bus.overrun_err, exp_ovr); else passes++;
      while (exp_q.size() != 0) begin
         checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_q[0]) $display("[TB] FAIL overrun_drain: got v=%b d=%h want v=1 d=%h", bus.rd_valid, bus.rd_data, exp_q[0]); else passes++;
         pop_one();
         void'(exp_q.pop_front());
      end
      checks++; if (bus.rd_valid !== 1'b0) $display("[TB] FAIL overrun_empty: rd_valid %b want 0", bus.rd_valid); else passes++;
      pulse_err_clr();
      checks++; if (bus.overrun_err !== 1'b0) $display("[TB] FAIL overrun_clr: got %b want 0", bus.overrun_err); else passes++;
   endtask

   task automatic test_push_pop_full();
      logic [7:0] b;
      baud_div = 16'd1;
      repeat (10) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, 16, 16);
         model_push(b);
      end
      @(negedge clk);
      fork
         send_frame(8'h77, 1'b1, 16, 16);
         begin
            repeat (154) @(posedge clk);
            @(negedge clk) bus.rd_ready = 1'b1;
            @(negedge clk) bus.rd_ready = 1'b0;
         end
      join
      void'(exp_q.pop_front());
      model_push(8'h77);
      repeat (20) @(negedge clk);
      checks++; if (bus.overrun_err !== exp_ovr) $display("[TB] FAIL pushpop_ovr: got %b want %b", bus.overrun_err, exp_ovr); else passes++;
      for (int k = 0; k < 4; k++) begin
         checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_q[0]) $display("[TB] FAIL pushpop_drain%0d: got v=%b d=%h want v=1 d=%h", k, bus.rd_valid, bus.rd_data, exp_q[0]); else passes++;
         pop_one();
         void'(exp_q.pop_front());
      end
      checks++; if (bus.rd_valid !== 1'b0) $display("[TB] FAIL pushpop_empty: rd_valid %b want 0", bus.rd_valid); else passes++;
   endtask

   task automatic test_abort_enable();
      logic [7:0] keep;
      keep = 8'($urandom);
      baud_div = 16'd1;
      repeat (10) @(negedge clk);
      send_frame(keep, 1'b1, 16, 16);
      model_push(keep);
      repeat (10) @(negedge clk);
      fork
         send_frame(8'($urandom), 1'b1, 16, 16);
         begin
            repeat (60) @(negedge clk);
            checks++; if (busy !== 1'b1) $display("[TB] FAIL abort_en_mid: busy %b want 1", busy); else passes++;
            enable = 1'b0;
            @(negedge clk);
            checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_en_idle: busy %b want 0", busy); else passes++;
         end
      join
      repeat (5) @(negedge clk);
      enable = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_q[0]) $display("[TB] FAIL abort_en_keep: got v=%b d=%h want v=1 d=%h", bus.rd_valid, bus.rd_data, exp_q[0]); else passes++;
      pop_one();
      void'(exp_q.pop_front());
      checks++; if (bus.rd_valid !== 1'b0) $display("[TB] FAIL abort_en_nopush: rd_valid %b want 0", bus.rd_valid); else passes++;
   endtask

   task automatic test_abort_reset();
      baud_div = 16'd1;
      repeat (10) @(negedge clk);
      send_frame(8'h5A, 1'b1, 16, 16);
      model_push(8'h5A);
      send_frame(8'h00, 1'b0, 16, 20);
      exp_fe = 1'b1;
      repeat (10) @(negedge clk);
      fork
         send_frame(8'($urandom), 1'b1, 16, 16);
         begin
            repeat (60) @(negedge clk);
            #1 reset = 1'b1;
            #1;
            checks++; if ({busy, dp_sample, bus.rd_valid} !== 3'b000) $display("[TB] FAIL reset_mid_ctl: got %b want 000", {busy, dp_sample, bus.rd_valid}); else passes++;
            checks++; if (bus.rd_data !== 8'h00 || {bus.framing_err, bus.overrun_err} !== 2'b00) $display("[TB] FAIL reset_mid_data: got d=%h e=%b want d=00 e=00", bus.rd_data, {bus.framing_err, bus.overrun_err}); else passes++;
         end
      join
      exp_q.delete();
      exp_fe = 1'b0;
      exp_ovr = 1'b0;
      @(negedge clk) reset = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if ({busy, bus.rd_valid} !== 2'b00) $display("[TB] FAIL reset_mid_after: got %b want 00", {busy, bus.rd_valid}); else passes++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         test_valid_byte(16'($urandom_range(0, 3)), 8'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_valid_byte(16'd1, 8'hA5);
      test_glitch();
      test_framing();
      test_overrun();
      test_push_pop_full();
      test_abort_enable();
      test_abort_reset();
      test_valid_byte(16'd3, 8'hA5);
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART path. Generates the 16x oversample tick from the system clock and detects and validates the start bit. It sequences mid-bit sampling of 8 data bits (LSB first) with a sample strobe to the datapath, and checks the stop bit. Completed bytes are buffered in a small FIFO with a valid/ready read handshake, and framing and overrun errors are flagged. It sits between the raw rx pin and the host-side register/bus interface.

Parameters:
DATA_BITS, 8, data bits per frame (LSB first, no parity, 1 stop bit)
OVS, 16, oversample ticks per bit period
FIFO_DEPTH, 4, receive buffer entries (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
enable  in  1  receiver enable; low aborts any frame in progress
baud_div  in  16  clk cycles per oversample tick; 0 treated as 1
rx  in  1  serial line, asynchronous, idle high
dp_sample  out  1  one-clk pulse at each data-bit mid-point sample
rd_data  out  DATA_BITS  FIFO head byte
rd_valid  out  1  FIFO not empty
rd_ready  in  1  consumer accepts head byte
framing_err  out  1  sticky; stop bit sampled low
overrun_err  out  1  sticky; byte completed while FIFO full
err_clr  in  1  clears both error flags
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: rx synchroniser flops = 1; tick counter = 0; FSM = IDLE; shift register = 0; FIFO empty; rd_valid = 0; rd_data = 0; dp_sample = 0; framing_err = 0; overrun_err = 0; busy = 0.
- rx synchroniser: rx passes through two flops to give rx_s. All decisions use rx_s.
- Tick generator:
  - div_cnt counts 0..baud_div-1. tick = 1 for one clk when div_cnt == baud_div-1, then div_cnt wraps to 0.
  - div_cnt is held at 0 while enable = 0.
  - A baud_div change takes effect at the next wrap.
- FSM: IDLE, START, DATA, STOP, WAIT_HIGH. It advances only on tick. os_cnt is 4 bits; bit_cnt is 3 bits.
  - IDLE: on tick with rx_s = 0, go to START with os_cnt = 0.
  - START: os_cnt increments each tick. At os_cnt == 7 (mid start bit):
    - rx_s = 0: go to DATA, os_cnt = 0, bit_cnt = 0.
    - rx_s = 1: glitch; return to IDLE, nothing recorded.
  - DATA: at os_cnt == 15:
    - shift rx_s into the MSB of a right-shifting register;
    - pulse dp_sample;
    - increment bit_cnt; os_cnt wraps to 0.
    - After the sample with bit_cnt == DATA_BITS-1, go to STOP.
  - STOP: at os_cnt == 15:
    - rx_s = 1: push the shift register into the FIFO and go to IDLE. If the FIFO is full with no pop in the same cycle, drop the byte and set overrun_err.
    - rx_s = 0: set framing_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: on tick with rx_s = 1, go to IDLE. This prevents a break condition from being taken as a new start bit.
- enable = 0: FSM forced to IDLE at the next clk. The partial frame is discarded; FIFO contents and error flags are retained.
- Latency: rd_valid rises 1 clk after the clk carrying the stop-bit sample tick.
- FIFO:
  - pop occurs when rd_valid && rd_ready; rd_data always shows the head entry.
  - Push and pop in the same cycle are both accepted, including when full (occupancy unchanged) and when empty-with-push (no pop possible; occupancy becomes 1).
  - Pointers are log2(FIFO_DEPTH)+1 bits, with natural wrap.
- Error flags: set has priority over err_clr in the same cycle.
- busy = (state != IDLE).
- Reset mid-frame: all state returns to reset values immediately (asynchronous). Any partial byte and FIFO contents are lost.

Decomposition:
- Shared package uart_pkg holds:
  - state enum rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH};
  - constants UART_OVS = 16, UART_MID = 7, UART_DATA_BITS = 8.
- One natural sub-module, uart_rx_fifo: synchronous FIFO with parameterised depth and width, exposing push, full, pop, empty and head data.
- Tick generator, synchroniser and FSM remain in uart_rx_ctrl.

Test Plan:
- Valid byte: baud_div = 1, enable = 1; drive frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) at 16 clk/bit → exactly 8 dp_sample pulses at mid-bit; rd_valid = 1 with rd_data = 0xA5; no error flags set.
- Start glitch: rx low for 4 ticks then high → FSM returns to IDLE at os_cnt 7; busy drops; no push; no errors.
- Framing error: frame 0x3C with stop bit low, held low 40 ticks, then high → framing_err = 1; FIFO stays empty; FSM stays in WAIT_HIGH until rx_s = 1. Next frame 0x11 is received correctly. err_clr then clears the flag.
- Overrun: rd_ready = 0; send 0x01..0x05 → after the 4th byte rd_valid = 1 and FIFO is full; 5th byte dropped and overrun_err = 1. Then rd_ready = 1 → pops 0x01, 0x02, 0x03, 0x04 in order, then rd_valid = 0.
- Simultaneous push/pop when full: FIFO full, rd_ready pulsed in the exact clk a 0x77 stop completes → 0x77 accepted, no overrun, occupancy stays 4.
- Abort: enable dropped mid-DATA, and separately reset asserted mid-DATA → FSM in IDLE with no partial push. With enable, FIFO contents are retained; with reset, all outputs are at reset values. baud_div = 3 rerun of the 0xA5 case gives 48 clk/bit timing.
